tdes_round_sequencer: RTL
=========================

// Module: tdes_round_sequencer
// PURPOSE
//  Sequences one 3DES block through the shared single-round DES datapath: 3 passes x 16 rounds.
//  Each cycle it addresses the round key: key-schedule bank, 4-key group, and the 2-bit index
//  the key handler uses to pick 1 of 4 48-bit subkeys. It also drives the datapath load/round/finish strobes.
//  Sits between the host block interface and the round datapath/key handler.
// PARAMETERS
//  ROUNDS      16  rounds per DES pass; multiple of 4, so each group holds 4 keys
//  PASSES      3   DES passes per block (EDE)
// PORTS
//  clk          in   1   clock; all state on rising edge
//  rst          in   1   asynchronous active-high reset
//  start        in   1   request to process a block; accepted only when in_ready=1
//  decrypt      in   1   mode, sampled with accepted start: 0=3DES encrypt, 1=3DES decrypt
//  abort        in   1   synchronous cancel of the current block
//  out_ready    in   1   consumer accepts result when out_valid=1
//  in_ready     out  1   1 only in IDLE
//  busy         out  1   1 in LOAD, ROUND, FINISH
//  load_blk     out  1   1-cycle strobe: datapath captures input block and applies IP
//  round_en     out  1   datapath performs one Feistel round this cycle
//  last_round   out  1   with round_en on a pass's final round: datapath suppresses L/R swap
//  pass_dec     out  1   current pass runs in decrypt direction
//  key_bank     out  2   DES key schedule in use: 0=K1, 1=K2, 2=K3
//  key_group    out  2   4-key group address into the selected schedule
//  key_count    out  2   subkey select to key handler (00 = bits 191:144 ... 11 = bits 47:0)
//  fin_blk      out  1   1-cycle strobe: datapath applies FP and registers the result
//  out_valid    out  1   result valid; held until out_ready
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, every other output 0, internal counters 0, mode latch 0.
//  FSM: IDLE -(start)-> LOAD -> ROUND -> FINISH -> HOLD -(out_ready)-> IDLE.
//  - LOAD is one cycle: load_blk=1, counters cleared.
//  - ROUND lasts PASSES*ROUNDS cycles with round_en=1 every cycle; no stalls.
//  - FINISH is one cycle: fin_blk=1.
//  - HOLD: out_valid=1 until the cycle out_ready=1, then IDLE; in_ready=1 the next cycle.
//  Latency: start accepted at edge 0; out_valid=1 after edge PASSES*ROUNDS+2 (50 by default).
//  Start is ignored outside IDLE and is never queued. Start and out_ready in the same cycle are
//  impossible, because in_ready and out_valid are mutually exclusive.
//  Counters: pass p in 0..PASSES-1, round r in 0..ROUNDS-1. r wraps to 0 and p increments at r=ROUNDS-1.
//  Per-pass schedule (mode latched at start):
//    encrypt: pass0 K1/enc, pass1 K2/dec, pass2 K3/enc.
//    decrypt: pass0 K3/dec, pass1 K2/enc, pass2 K1/dec.
//  Key index k = r for an enc pass, ROUNDS-1-r for a dec pass.
//  key_group = k[3:2] and key_count = k[1:0]. Both are registered outputs, valid in the same cycle as round_en.
//  last_round=1 when r=ROUNDS-1.
//  key_bank, key_group, key_count and pass_dec hold their last values outside ROUND; they are 0 after reset.
//  abort: from any state except IDLE, go to IDLE next cycle. All strobes and out_valid deassert;
//    no fin_blk is issued. abort in IDLE has no effect. abort has priority over out_ready.
//  rst asserted mid-block: immediate return to reset values; the partial block is discarded.
// TESTING
//  1. Reset, start=1 decrypt=0 -> load_blk at cycle 1; 48 round_en cycles; fin_blk at cycle 50;
//     out_valid at 51; in_ready back to 1 one cycle after out_ready.
//  2. Encrypt key trace -> bank/group/count = 0/0/0,0/0/1..0/3/3, then 1/3/3 down to 1/0/0, then
//     2/0/0..2/3/3; pass_dec=0,1,0.
//  3. Decrypt key trace -> bank 2 counting down from 3/3, bank 1 counting up, bank 0 counting down;
//     pass_dec=1,0,1.
//  4. last_round check -> asserted exactly at ROUND cycles 15, 31 and 47.
//  5. Start pulsed during ROUND and HOLD -> ignored. out_ready held low 10 cycles -> out_valid stays 1
//     with no extra strobes.
//  6. abort at ROUND cycle 20 -> IDLE next cycle, no fin_blk. rst at cycle 30 of a new block ->
//     all outputs at reset values immediately, and a following start runs normally.

Source files
------------

// File: rtl/tdes_round_sequencer.sv
// ============================================================================
// Module      : tdes_round_sequencer
// Description : Drives one 3DES block through a shared single-round DES
//               datapath (PASSES x ROUNDS) and addresses the round subkeys.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdes_round_sequencer #(
    parameter int ROUNDS = 16,
    parameter int PASSES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       decrypt,
    input  logic       abort,
    input  logic       out_ready,
    output logic       in_ready,
    output logic       busy,
    output logic       load_blk,
    output logic       round_en,
    output logic       last_round,
    output logic       pass_dec,
    output logic [1:0] key_bank,
    output logic [1:0] key_group,
    output logic [1:0] key_count,
    output logic       fin_blk,
    output logic       out_valid
);

    localparam logic [3:0] c_R_LAST = 4'(ROUNDS - 1);
    localparam logic [1:0] c_P_LAST = 2'(PASSES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ROUND  = 3'd2,
        S_FINISH = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_n;
    logic [3:0] r_round;
    logic [3:0] w_round_n;
    logic [1:0] r_pass;
    logic [1:0] w_pass_n;
    logic       r_dec_mode;
    logic       w_dec_n;
    logic [1:0] w_bank_n;
    logic [3:0] w_key_idx_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_round    <= 4'd0;
            r_pass     <= 2'd0;
            r_dec_mode <= 1'b0;
            pass_dec   <= 1'b0;
            key_bank   <= 2'd0;
            key_group  <= 2'd0;
            key_count  <= 2'd0;
        end else begin
            r_state <= w_state_n;
            r_round <= w_round_n;
            r_pass  <= w_pass_n;
            if (r_state == S_IDLE && start) begin
                r_dec_mode <= decrypt;
            end
            // Key address is computed one cycle ahead so it lines up with round_en.
            if (w_state_n == S_ROUND) begin
                pass_dec  <= w_dec_n;
                key_bank  <= w_bank_n;
                key_group <= w_key_idx_n[3:2];
                key_count <= w_key_idx_n[1:0];
            end
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_round_n  = r_round;
        w_pass_n   = r_pass;
        in_ready   = 1'b0;
        busy       = 1'b0;
        load_blk   = 1'b0;
        round_en   = 1'b0;
        last_round = 1'b0;
        fin_blk    = 1'b0;
        out_valid  = 1'b0;

        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (start) begin
                    w_state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                busy      = 1'b1;
                load_blk  = 1'b1;
                w_round_n = 4'd0;
                w_pass_n  = 2'd0;
                w_state_n = S_ROUND;
            end
            S_ROUND: begin
                busy       = 1'b1;
                round_en   = 1'b1;
                last_round = (r_round == c_R_LAST);
                if (r_round == c_R_LAST) begin
                    w_round_n = 4'd0;
                    if (r_pass == c_P_LAST) begin
                        w_state_n = S_FINISH;
                    end else begin
                        w_pass_n = r_pass + 2'd1;
                    end
                end else begin
                    w_round_n = r_round + 4'd1;
                end
            end
            S_FINISH: begin
                busy      = 1'b1;
                fin_blk   = 1'b1;
                w_state_n = S_HOLD;
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        if (abort && r_state != S_IDLE) begin
            w_state_n = S_IDLE;
        end
    end

    // EDE: the middle pass runs opposite to the block mode; decrypt walks banks K3..K1.
    assign w_dec_n     = r_dec_mode ^ w_pass_n[0];
    assign w_bank_n    = r_dec_mode ? (c_P_LAST - w_pass_n) : w_pass_n;
    assign w_key_idx_n = w_dec_n ? (c_R_LAST - w_round_n) : w_round_n;

endmodule

`default_nettype wire
